// File: rtl/clk_div_meter.sv
// Measures period and high time of a divided clock sampled in the clk domain and reports lock.
// Optional INPUT_SYNC_EN adds a 2-flop synchroniser in front of the sampling flop for async sources.
module clk_div_meter #(
  parameter int CNT_W         = 8,
  parameter int EXPECT_PERIOD = 6,
  parameter int EXPECT_HIGH   = 3,
  parameter int LOCK_CNT      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             error
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] EXP_P    = CNT_W'(EXPECT_PERIOD);
  localparam logic [CNT_W-1:0] EXP_H    = CNT_W'(EXPECT_HIGH);
  localparam logic [3:0]       LOCK_N   = 4'(LOCK_CNT);

  logic             samp_in_s;
  logic             s_r, prev_r;
  logic             edge_s, timeout_s, match_s;
  logic [1:0]       state_r, state_nx;
  logic [CNT_W-1:0] per_cnt_r, per_cnt_nx, per_inc_s;
  logic [CNT_W-1:0] hi_cnt_r, hi_cnt_nx, hi_inc_s;
  logic [3:0]       match_r, match_nx, match_inc_s;
  logic [CNT_W-1:0] period_r, period_nx, high_r, high_nx;
  logic             mv_r, mv_nx, locked_r, locked_nx, error_r, error_nx;

`ifdef INPUT_SYNC_EN
  logic [1:0] sync_r;

  // Two-stage synchroniser ahead of the sampling flop
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], div_in};
    end
  end

  assign samp_in_s = sync_r[1];
`else
  assign samp_in_s = div_in;
`endif

  // Sampling flop and its delayed copy for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s_r    <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      s_r    <= samp_in_s;
      prev_r <= s_r;
    end
  end

  assign edge_s      = s_r & ~prev_r;
  assign timeout_s   = (per_cnt_r == CNT_MAX) & ~edge_s;
  assign match_s     = (per_cnt_r == EXP_P) && (hi_cnt_r == EXP_H);
  assign per_inc_s   = (per_cnt_r == CNT_MAX) ? per_cnt_r : per_cnt_r + CNT_ONE;
  assign hi_inc_s    = (hi_cnt_r == CNT_MAX || !s_r) ? hi_cnt_r : hi_cnt_r + CNT_ONE;
  assign match_inc_s = (match_r == 4'd15) ? match_r : match_r + 4'd1;

  // Next-state logic: counters restart at 1 on an edge because the edge cycle itself is high
  always_comb begin
    state_nx   = state_r;
    per_cnt_nx = per_inc_s;
    hi_cnt_nx  = hi_inc_s;
    match_nx   = match_r;
    period_nx  = period_r;
    high_nx    = high_r;
    mv_nx      = 1'b0;
    locked_nx  = locked_r;
    error_nx   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (edge_s) begin
          state_nx   = ST_MEASURE;
          per_cnt_nx = CNT_ONE;
          hi_cnt_nx  = CNT_ONE;
        end else begin
          per_cnt_nx = CNT_ZERO;
          hi_cnt_nx  = CNT_ZERO;
        end
      end
      ST_MEASURE, ST_LOCKED: begin
        if (edge_s) begin
          period_nx  = per_cnt_r;
          high_nx    = hi_cnt_r;
          mv_nx      = 1'b1;
          per_cnt_nx = CNT_ONE;
          hi_cnt_nx  = CNT_ONE;
          if (state_r == ST_LOCKED) begin
            if (!match_s) begin
              state_nx  = ST_MEASURE;
              match_nx  = 4'd0;
              locked_nx = 1'b0;
              error_nx  = 1'b1;
            end else begin
              state_nx  = ST_LOCKED;
            end
          end else if (match_s) begin
            match_nx = match_inc_s;
            if (match_inc_s >= LOCK_N) begin
              state_nx  = ST_LOCKED;
              locked_nx = 1'b1;
            end else begin
              state_nx  = ST_MEASURE;
            end
          end else begin
            match_nx = 4'd0;
          end
        end else if (timeout_s) begin
          state_nx   = ST_IDLE;
          per_cnt_nx = CNT_ZERO;
          hi_cnt_nx  = CNT_ZERO;
          match_nx   = 4'd0;
          locked_nx  = 1'b0;
          error_nx   = 1'b1;
        end else begin
          state_nx = state_r;
        end
      end
      default: begin
        state_nx   = ST_IDLE;
        per_cnt_nx = CNT_ZERO;
        hi_cnt_nx  = CNT_ZERO;
        match_nx   = 4'd0;
        locked_nx  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      per_cnt_r <= CNT_ZERO;
      hi_cnt_r  <= CNT_ZERO;
      match_r   <= 4'd0;
      period_r  <= CNT_ZERO;
      high_r    <= CNT_ZERO;
      mv_r      <= 1'b0;
      locked_r  <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      state_r   <= state_nx;
      per_cnt_r <= per_cnt_nx;
      hi_cnt_r  <= hi_cnt_nx;
      match_r   <= match_nx;
      period_r  <= period_nx;
      high_r    <= high_nx;
      mv_r      <= mv_nx;
      locked_r  <= locked_nx;
      error_r   <= error_nx;
    end
  end

  assign period     = period_r;
  assign high_time  = high_r;
  assign meas_valid = mv_r;
  assign locked     = locked_r;
  assign error      = error_r;

endmodule
